// File: rtl/frame_arbiter_pkg.sv
// Shared types for the frame arbiter: the two-state grant controller.
package frame_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

endpackage

// File: rtl/frame_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester strictly after the last grant,
// wrapping around, so the most recently served source has lowest priority.
module rr_picker #(
    parameter int NUM_SRC = 4,
    localparam int IDX_W  = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic [IDX_W-1:0]   grant_o,
    output logic               any_o
);

    logic found;
    int   idx;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            idx = (int'(last_i) + k) % NUM_SRC;
            if (!found && req_i[idx]) begin
                grant_o = IDX_W'(idx);
                found   = 1'b1;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/frame_arbiter.sv
// Frame-granular round-robin arbiter: a granted source owns the downstream port
// for exactly FRAME_LEN transfers; data and handshakes pass through combinationally.
module frame_arbiter
    import frame_arbiter_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int FRAME_LEN  = 64,
    localparam int IDX_W     = $clog2(NUM_SRC),
    localparam int CNT_W     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1
) (
    input  logic                          clkIn,
    input  logic                          rstIn,
    input  logic [NUM_SRC-1:0]            srcValidIn,
    output logic [NUM_SRC-1:0]            srcConsentOut,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] srcDataIn,
    output logic                          dstValidOut,
    input  logic                          dstConsentIn,
    output logic [DATA_WIDTH-1:0]         dstDataOut,
    output logic [IDX_W-1:0]              dstSrcIdOut,
    output logic                          dstLastOut
);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] last_grant_q, last_grant_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [IDX_W-1:0] pick;
    logic             any_req;

    rr_picker #(.NUM_SRC(NUM_SRC)) u_picker (
        .req_i   (srcValidIn),
        .last_i  (last_grant_q),
        .grant_o (pick),
        .any_o   (any_req)
    );

    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            beat_cnt_q   <= '0;
            last_grant_q <= IDX_W'(NUM_SRC - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            beat_cnt_q   <= beat_cnt_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        beat_cnt_d    = beat_cnt_q;
        last_grant_d  = last_grant_q;
        srcConsentOut = '0;
        dstValidOut   = 1'b0;
        dstDataOut    = '0;
        dstSrcIdOut   = '0;
        dstLastOut    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d    = pick;
                    beat_cnt_d = '0;
                    state_d    = BURST;
                end
            end
            BURST: begin
                dstValidOut            = srcValidIn[grant_q];
                srcConsentOut[grant_q] = dstConsentIn;
                dstDataOut             = srcDataIn[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
                dstSrcIdOut            = grant_q;
                dstLastOut             = dstValidOut && (beat_cnt_q == CNT_W'(FRAME_LEN - 1));
                // Counter stops at FRAME_LEN-1; the last beat leaves BURST instead of wrapping.
                if (dstValidOut && dstConsentIn) begin
                    if (dstLastOut) begin
                        last_grant_d = grant_q;
                        state_d      = IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
